// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the SM510 program ROM loader.
package rom_loader_pkg;

  localparam int unsigned ROM_ADDR_W = 12;
  localparam int unsigned ROM_BYTES  = 4096;

  typedef enum logic [1:0] {
    IDLE,
    UNPACK,
    DONE
  } rom_loader_state_t;

  // Big-endian byte select: index 0 is bits [31:24].
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    logic [31:0] shifted;
    shifted = word << {idx, 3'b000};
    return shifted[31:24];
  endfunction

endpackage

// File: rtl/rom_loader_ram.sv
// Simple dual-port 4096x8 ROM image store: one write port, one registered read port.
module rom_loader_ram
  import rom_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ROM_ADDR_W-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  rd_en,
  input  logic [ROM_ADDR_W-1:0] rd_addr,
  output logic [7:0]            rd_data
);

  logic [7:0] mem [ROM_BYTES];

  // The array itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rom_loader.sv
// Unpacks the bridge word stream into the SM510 program ROM and serves CPU fetches.
// Optional ROM_LOADER_CHECKSUM_EN adds a 16-bit running sum of written bytes.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned ROM_SIZE = ROM_BYTES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  input  logic                  in_last,
  input  logic                  clk_en,
  input  logic [ROM_ADDR_W-1:0] rom_addr,
  output logic [7:0]            rom_data,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [12:0]           byte_count
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]           checksum
`endif
);

  localparam logic [12:0] SIZE_LIM = 13'(ROM_SIZE);

  rom_loader_state_t state, state_next;
  logic [31:0] word_q;
  logic        last_q;
  logic [1:0]  idx;
  logic        accept;
  logic        wr_en;
  logic        overflow;
  logic [7:0]  wr_data;

  assign accept  = in_valid && in_ready;
  assign wr_data = byte_of(word_q, idx);

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    wr_en      = 1'b0;
    overflow   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = !reset;
        if (in_valid && !reset) state_next = UNPACK;
      end
      UNPACK: begin
        // A reset landing mid-word must not commit the pending byte.
        if (byte_count == SIZE_LIM) overflow = 1'b1;
        else                        wr_en    = !reset;
        if (idx == 2'd3) state_next = last_q ? DONE : IDLE;
      end
      DONE: ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      word_q     <= '0;
      last_q     <= 1'b0;
      idx        <= '0;
      byte_count <= '0;
      load_error <= 1'b0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
    end else begin
      state     <= state_next;
      cpu_reset <= (state != DONE);
      load_done <= (state == DONE);
      if (accept) begin
        word_q <= in_data;
        last_q <= in_last;
        idx    <= '0;
      end else if (state == UNPACK) begin
        idx <= idx + 2'd1;
      end
      if (wr_en)    byte_count <= byte_count + 13'd1;
      if (overflow) load_error <= 1'b1;
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)      checksum <= '0;
    else if (wr_en) checksum <= checksum + {8'h00, wr_data};
  end
`endif

  rom_loader_ram u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (byte_count[ROM_ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (clk_en),
    .rd_addr (rom_addr),
    .rd_data (rom_data)
  );

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: a byte-array image model predicts ROM contents and status.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        clk_en = 1'b0;
  logic [11:0] rom_addr = '0;
  logic [7:0]  rom_data;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;
  logic [12:0] byte_count;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  rom_loader #(.ROM_SIZE(4096)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .clk_en     (clk_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error),
    .byte_count (byte_count)
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference image model
  logic [7:0]  m_mem [4096];
  bit          m_known [4096];
  int          m_cnt = 0;
  bit          m_err = 1'b0;
  int          m_cks = 0;

  logic [31:0] tx_q [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  last_exp = '0;
  logic        rd_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_cnt = 0;
    m_err = 1'b0;
    m_cks = 0;
  endfunction

  function automatic void model_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      logic [7:0] by;
      by = 8'((w >> (8 * (3 - b))) & 32'hFF);
      if (m_cnt >= 4096) m_err = 1'b1;
      else begin
        m_mem[m_cnt]   = by;
        m_known[m_cnt] = 1'b1;
        m_cks          = (m_cks + int'(by)) % 65536;
        m_cnt++;
      end
    end
  endfunction

  // Read-side monitor: any clk_en cycle yields a byte one clock later.
  always @(posedge clk) rd_pend <= clk_en;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) check("rd_unexpected", 32'(rom_data), 32'hFFFF_FFFF);
      else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("rom_data", 32'(rom_data), 32'(e));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; clk_en = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_cpu_reset", 32'(cpu_reset), 1);
    check("rst_load_done", 32'(load_done), 0);
    check("rst_load_error", 32'(load_error), 0);
    check("rst_byte_count", 32'(byte_count), 0);
    check("rst_rom_data", 32'(rom_data), 0);
`ifdef ROM_LOADER_CHECKSUM_EN
    check("rst_checksum", 32'(checksum), 0);
`endif
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 1);
  endtask

  // Streams tx_q with in_valid held high; returns at the negedge after the final accept.
  task automatic send_stream(input bit with_last);
    int cyc = 0;
    int last_acc = -1;
    int budget = 10 * tx_q.size() + 20;
    while (tx_q.size() > 0) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = tx_q[0];
      in_last  = with_last && (tx_q.size() == 1);
      if (in_ready) begin
        if (last_acc >= 0) check("ready_gap", 32'(cyc - last_acc), 5);
        last_acc = cyc;
        model_word(tx_q.pop_front());
      end
      cyc++;
      if (cyc > budget) begin
        check("stream_timeout", 32'(tx_q.size()), 0);
        tx_q.delete();
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done_and_check();
    for (int i = 0; i < 20; i++) begin
      if (load_done === 1'b1) break;
      @(negedge clk);
    end
    check("load_done", 32'(load_done), 1);
    check("cpu_reset_released", 32'(cpu_reset), 0);
    check("byte_count", 32'(byte_count), 32'(m_cnt));
    check("load_error", 32'(load_error), 32'(m_err));
`ifdef ROM_LOADER_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(m_cks));
`endif
  endtask

  task automatic read_addr(input logic [11:0] a);
    @(negedge clk);
    clk_en   = 1'b1;
    rom_addr = a;
    exp_q.push_back(m_mem[a]);
    last_exp = m_mem[a];
  endtask

  task automatic finish_reads();
    @(negedge clk);
    clk_en   = 1'b0;
    rom_addr = 12'(($urandom & 32'hFFF));
    repeat (3) @(negedge clk);
    check("rd_hold", 32'(rom_data), 32'(last_exp));
    check("rd_q_drain", 32'(exp_q.size()), 0);
  endtask

  task automatic random_reads(input int n);
    for (int i = 0; i < n; i++) begin
      int a;
      a = int'($urandom_range(4095, 0));
      while (!m_known[a]) a = (a + 1) % 4096;
      read_addr(12'(a));
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) m_known[i] = 1'b0;

    // Single word: byte order, completion latency, read latency.
    do_reset();
    tx_q.push_back(32'hA1B2_C3D4);
    send_stream(1'b1);
    repeat (4) @(negedge clk);
    check("done_not_early", 32'(load_done), 0);
    check("cpu_reset_held", 32'(cpu_reset), 1);
    @(negedge clk);
    check("done_6_after_accept", 32'(load_done), 1);
    check("cpu_reset_6_after", 32'(cpu_reset), 0);
    wait_done_and_check();
    check("single_count", 32'(byte_count), 4);
    for (int a = 0; a < 4; a++) read_addr(12'(a));
    read_addr(12'd2);
    finish_reads();

    // DONE ignores a continuously valid stream.
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = $urandom;
      @(negedge clk);
      check("done_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    check("done_count_frozen", 32'(byte_count), 4);
    check("done_still", 32'(load_done), 1);

    // Full image with incrementing bytes.
    do_reset();
    for (int w = 0; w < 1024; w++)
      tx_q.push_back({8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)});
    send_stream(1'b1);
    wait_done_and_check();
    check("full_count", 32'(byte_count), 4096);
    check("full_no_error", 32'(load_error), 0);
    read_addr(12'hFFF);
    read_addr(12'h000);
    random_reads(24);
    finish_reads();

    // Overflow by one word of random data.
    do_reset();
    for (int w = 0; w < 1025; w++) tx_q.push_back($urandom);
    send_stream(1'b1);
    wait_done_and_check();
    check("ovf_error", 32'(load_error), 1);
    check("ovf_count", 32'(byte_count), 4096);
    read_addr(12'h000);
    read_addr(12'hFFF);
    random_reads(16);
    finish_reads();

    // Reset during UNPACK index 2, then reload.
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = $urandom; in_last = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_count_pre", 32'(byte_count), 2);
    reset = 1'b1;
    @(negedge clk);
    check("mid_count_cleared", 32'(byte_count), 0);
    check("mid_cpu_reset", 32'(cpu_reset), 1);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    tx_q.push_back(32'h0102_0304);
    send_stream(1'b1);
    wait_done_and_check();
    for (int a = 0; a < 4; a++) read_addr(12'(a));
    random_reads(8);
    finish_reads();

    // Checksum wrap case: 4*0xFF + 0x01.
    do_reset();
    tx_q.push_back(32'hFFFF_FFFF);
    tx_q.push_back(32'h0000_0001);
    send_stream(1'b1);
    wait_done_and_check();
`ifdef ROM_LOADER_CHECKSUM_EN
    check("checksum_const", 32'(checksum), 32'h03FD);
`endif
    read_addr(12'd4);
    read_addr(12'd7);
    finish_reads();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
